// File: rtl/divider_seq_8bit.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per cycle.
// Latency: 9 edges from accepted start to done (1 edge for a zero divisor); start is ignored while busy.
module divider_seq_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t     r_state;
    logic [7:0] r_q;
    logic [7:0] r_d;
    logic [7:0] r_r;
    logic [2:0] r_cnt;

    logic [7:0] w_trial;
    logic [7:0] w_diff;
    logic [8:0] w_borrow;
    logic       w_ok;
    logic [7:0] w_r_next;
    logic [7:0] w_q_next;

    // Explicit ripple-borrow subtract so the final borrow doubles as the compare result.
    always_comb begin
        w_trial     = {r_r[6:0], r_q[7]};
        w_diff      = 8'd0;
        w_borrow    = 9'd0;
        for (int i = 0; i < 8; i++) begin
            w_diff[i]       = w_trial[i] ^ r_d[i] ^ w_borrow[i];
            w_borrow[i + 1] = (~w_trial[i] & r_d[i]) | (~(w_trial[i] ^ r_d[i]) & w_borrow[i]);
        end
        // A set R[7] means the trial value is really 9 bits wide and always exceeds D.
        w_ok        = r_r[7] | ~w_borrow[8];
        w_r_next    = w_ok ? w_diff : w_trial;
        w_q_next    = {r_q[6:0], w_ok};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_q         <= 8'd0;
            r_d         <= 8'd0;
            r_r         <= 8'd0;
            r_cnt       <= 3'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= 8'd0;
            remainder   <= 8'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_q   <= dividend;
                        r_d   <= divisor;
                        r_r   <= 8'd0;
                        r_cnt <= 3'd0;
                        if (divisor != 8'd0) begin
                            r_state <= S_RUN;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end else begin
                            r_state     <= S_DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= 8'hFF;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state     <= S_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= w_q_next;
                        remainder   <= w_r_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq_8bit.sv
// Bench for divider_seq_8bit: directed and random divisions against an arithmetic reference.
module tb_divider_seq_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    divider_seq_8bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division; zero divisor yields all-ones quotient and the dividend.
    function automatic logic [16:0] ref_div(input logic [7:0] a, input logic [7:0] b);
        if (b == 8'd0) return {1'b1, 8'hFF, a};
        return {1'b0, 8'(a / b), 8'(a % b)};
    endfunction

    // Present operands with start for one edge, then scramble operands.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
    endtask

    // Count cycles (first cycle after acceptance = 1) until done, bounded.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, div_by_zero} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero});
        else n_pass++;
        n_checks++;
        if ({quotient, remainder} !== 16'h0000) $display("FAIL reset_data got %h want 0000", {quotient, remainder});
        else n_pass++;
    endtask

    task automatic test_vector(input logic [7:0] a, input logic [7:0] b);
        logic [16:0] exp;
        int lat, bc;
        exp = ref_div(a, b);
        launch(a, b);
        wait_done(lat, bc);
        n_checks++;
        if (lat !== ((b == 0) ? 1 : 9)) $display("FAIL lat %0d/%0d got %0d want %0d", a, b, lat, (b == 0) ? 1 : 9);
        else n_pass++;
        n_checks++;
        if (bc !== ((b == 0) ? 0 : 8)) $display("FAIL busy_cycles %0d/%0d got %0d want %0d", a, b, bc, (b == 0) ? 0 : 8);
        else n_pass++;
        n_checks++;
        if ({div_by_zero, quotient, remainder} !== exp)
            $display("FAIL result %0d/%0d got dbz=%b q=%0d r=%0d want dbz=%b q=%0d r=%0d",
                     a, b, div_by_zero, quotient, remainder, exp[16], exp[15:8], exp[7:0]);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || {div_by_zero, quotient, remainder} !== exp)
            $display("FAIL hold %0d/%0d got done=%b q=%0d r=%0d want done=0 q=%0d r=%0d",
                     a, b, done, quotient, remainder, exp[15:8], exp[7:0]);
        else n_pass++;
    endtask

    task automatic test_directed();
        test_vector(8'd100, 8'd7);
        test_vector(8'd255, 8'd200);
        test_vector(8'd255, 8'd1);
        test_vector(8'd5,   8'd9);
        test_vector(8'd200, 8'd0);
        test_vector(8'd9,   8'd3);
    endtask

    task automatic test_ignore_start();
        int lat, bc, bad;
        logic [15:0] prev;
        prev = {quotient, remainder};
        bad  = 0;
        launch(8'd100, 8'd7);
        for (int i = 0; i < 7; i++) begin
            if (busy !== 1'b1 || done !== 1'b0 || {quotient, remainder} !== prev) bad++;
            start    = 1'($urandom);
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_done(lat, bc);
        n_checks++;
        if (bad !== 0) $display("FAIL ignore_run got %0d bad cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if (lat !== 2 || {quotient, remainder} !== {8'd14, 8'd2})
            $display("FAIL ignore_result got lat=%0d q=%0d r=%0d want lat=2 q=14 r=2", lat, quotient, remainder);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int dones;
        launch(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        n_checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 19'd0)
            $display("FAIL midrst_outputs got busy=%b done=%b dbz=%b q=%0d r=%0d want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        else n_pass++;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        n_checks++;
        if (dones !== 0) $display("FAIL midrst_quiet got %0d active cycles want 0", dones);
        else n_pass++;
        test_vector(8'd50, 8'd6);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a2, b2;
        logic [16:0] e1, e2;
        int lat, bc;
        a2 = 8'($urandom);
        b2 = 8'($urandom_range(1, 255));
        e1 = ref_div(8'd77, 8'd5);
        e2 = ref_div(a2, b2);
        @(negedge clk);
        start = 1'b1; dividend = 8'd77; divisor = 8'd5;
        @(negedge clk);
        dividend = a2; divisor = b2;
        wait_done(lat, bc);
        n_checks++;
        if (lat !== 9 || {div_by_zero, quotient, remainder} !== e1)
            $display("FAIL b2b_first got lat=%0d q=%0d r=%0d want lat=9 q=%0d r=%0d", lat, quotient, remainder, e1[15:8], e1[7:0]);
        else n_pass++;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_accept got done=%b busy=%b want done=0 busy=1", done, busy);
        else n_pass++;
        wait_done(lat, bc);
        n_checks++;
        if (lat !== 9 || bc !== 8 || {div_by_zero, quotient, remainder} !== e2)
            $display("FAIL b2b_second %0d/%0d got lat=%0d busy=%0d q=%0d r=%0d want lat=9 busy=8 q=%0d r=%0d",
                     a2, b2, lat, bc, quotient, remainder, e2[15:8], e2[7:0]);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) $display("FAIL b2b_single_pulse got done=%b want 0", done);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            test_vector(a, b);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/divider_seq_8bit.md
DIVIDER_SEQ_8BIT -- requirements
Module: divider_seq_8bit

Interface
REQ-001 No parameters; operand width fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a division; sampled on rising edge.
REQ-005 dividend  input  8  unsigned dividend; sampled only in the cycle start is accepted.
REQ-006 divisor  input  8  unsigned divisor; sampled only in the cycle start is accepted.
REQ-007 busy  output  1  high while an iteration sequence is running.
REQ-008 done  output  1  one-cycle pulse when a result becomes valid.
REQ-009 quotient  output  8  registered quotient of the last completed division.
REQ-010 remainder  output  8  registered remainder of the last completed division.
REQ-011 div_by_zero  output  1  registered flag; set with the result of a zero-divisor request.

Function
REQ-012 The FSM SHALL have three states:
- IDLE
- RUN
- DONE
REQ-013 Start SHALL be accepted in IDLE or DONE.
- On acceptance: latch the operands, clear the partial remainder R[7:0] and the iteration counter (3 bits).
- Go to RUN if divisor != 0, else go to DONE.
REQ-014 Start SHALL be ignored while in RUN; operands and progress SHALL be unaffected.
REQ-015 Each RUN edge SHALL perform one restoring-division iteration:
- trial = {R[6:0], Q[7]}, where Q is the working dividend/quotient register;
- diff = trial - D via an 8-bit borrow-chain subtract with borrow-in 0;
- ok = R[7] | ~borrow_out.
REQ-016 If ok: R <= diff and Q <= {Q[6:0],1}. Otherwise: R <= trial and Q <= {Q[6:0],0}.
- R[7] covers the 9-bit case: trial >= 256 > D, so diff mod 256 is correct.
REQ-017 RUN SHALL last exactly 8 edges. The 8th edge SHALL:
- go to DONE;
- load quotient <= new Q and remainder <= new R;
- clear div_by_zero.
REQ-018 Zero-divisor acceptance SHALL go straight to DONE and load quotient <= 8'hFF, remainder <= latched dividend, div_by_zero <= 1. No RUN cycles; busy stays 0.
REQ-019 busy SHALL be 1 exactly when the state is RUN.
REQ-020 done SHALL be 1 exactly when the state is DONE, for one cycle.
- DONE SHALL go to IDLE, or to RUN/DONE if start is accepted that edge (back-to-back).
REQ-021 Latency: start accepted at edge N; busy high for cycles N+1..N+8; done high in the cycle after edge N+8 (9 edges after acceptance). Zero divisor: done high in the cycle after edge N.
REQ-022 quotient, remainder and div_by_zero SHALL hold their last values until the next completion.
- They SHALL NOT change during RUN.
- Internal registers SHALL NOT be visible on outputs.
REQ-023 Operand changes after acceptance SHALL NOT affect the result.

Reset
REQ-024 rst SHALL win over start, including mid-RUN and in DONE.
REQ-025 On an rst edge:
- state = IDLE;
- busy = 0, done = 0;
- quotient = 0, remainder = 0, div_by_zero = 0;
- internal Q, D, R and counter cleared.
REQ-026 A sequence interrupted by reset SHALL NOT produce a done pulse or update the outputs.

Verification
REQ-027 100/7 -> busy 8 cycles, then done=1 with quotient=14, remainder=2, div_by_zero=0.
REQ-028 255/200 (R[7] path) -> quotient=1, remainder=55; 255/1 -> quotient=255, remainder=0; 5/9 -> quotient=0, remainder=5.
REQ-029 200/0 -> done in the cycle after acceptance with busy never high; quotient=8'hFF, remainder=8'hC8, div_by_zero=1. A following 9/3 clears div_by_zero and gives quotient=3, remainder=0.
REQ-030 Start 100/7, then start pulses and operand changes during RUN -> ignored; result 14/2 at the expected cycle.
REQ-031 Start 100/7, assert rst at the 4th RUN cycle -> busy=0 next cycle, all outputs 0, no done pulse. A fresh 50/6 then yields quotient=8, remainder=2.
REQ-032 Back-to-back: start held high through DONE -> new division accepted in the DONE cycle. Second result valid 9 edges later; one done pulse per division.
